// File: rtl/types_pkg.sv
// Shared bus-agent constants and the snoop bus arbiter state encoding.
package types;

  localparam int NUM_CPUS           = 4;
  localparam int ARB_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above prio_ptr, wrapping.
module rr_picker #(
  parameter int NUM_CPUS = 4,
  parameter int IW       = $clog2(NUM_CPUS)
) (
  input  logic [NUM_CPUS-1:0] req,
  input  logic [IW-1:0]       prio_ptr,
  output logic                found,
  output logic [IW-1:0]       idx
);

  // cand[k] is the agent index examined at search position k.
  logic [IW-1:0] cand [NUM_CPUS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CPUS; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum      = {1'b0, prio_ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(NUM_CPUS)) ? IW'(sum - (IW+1)'(NUM_CPUS))
                                                   : sum[IW-1:0];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (!found && req[cand[i]]) begin
        found = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter holding the grant for a full transaction with a dead cycle between owners.
// Optional ownership watchdog enabled by defining SNOOP_ARB_TIMEOUT_EN.
module snoop_bus_arbiter #(
  parameter int NUM_CPUS       = types::NUM_CPUS,
  parameter int TIMEOUT_CYCLES = types::ARB_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CPUS-1:0]         req,
  input  logic                        bus_done,
  output logic [NUM_CPUS-1:0]         gnt,
  output logic                        busy,
  output logic [$clog2(NUM_CPUS)-1:0] owner,
  output logic                        timeout_err
);

  import types::*;

  localparam int IW = $clog2(NUM_CPUS);

  generate
    if (NUM_CPUS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("snoop_bus_arbiter: NUM_CPUS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  arb_state_t          state_reg, state_next;
  logic [NUM_CPUS-1:0] gnt_reg, gnt_next;
  logic [IW-1:0]       owner_reg, owner_next;
  logic [IW-1:0]       prio_reg, prio_next;
  logic                timeout_reg, timeout_next;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                wd_expire;
  logic                release_now;

  rr_picker #(
    .NUM_CPUS (NUM_CPUS),
    .IW       (IW)
  ) u_picker (
    .req      (req),
    .prio_ptr (prio_reg),
    .found    (pick_found),
    .idx      (pick_idx)
  );

`ifdef SNOOP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_reg, wd_cnt_next;

  // Counter is zero on the first BUSY cycle, so cnt == T-1 marks the T-th owned cycle.
  always_comb begin
    wd_cnt_next = '0;
    if (state_reg == ARB_BUSY) begin
      wd_cnt_next = wd_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
    end
  end

  assign wd_expire = (state_reg == ARB_BUSY) && (wd_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  assign release_now = bus_done || !req[owner_reg] || wd_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      gnt_reg     <= '0;
      owner_reg   <= '0;
      prio_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      owner_reg   <= owner_next;
      prio_reg    <= prio_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (pick_found)  state_next = ARB_BUSY;
      ARB_BUSY: if (release_now) state_next = ARB_GAP;
      ARB_GAP:                   state_next = ARB_IDLE;
      default:                   state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_next     = gnt_reg;
    owner_next   = owner_reg;
    prio_next    = prio_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_found) begin
          gnt_next           = '0;
          gnt_next[pick_idx] = 1'b1;
          owner_next         = pick_idx;
          prio_next          = (pick_idx == IW'(NUM_CPUS - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      ARB_BUSY: begin
        if (release_now) begin
          gnt_next     = '0;
          // A voluntary release in the expiry cycle is not a timeout.
          timeout_next = wd_expire && !bus_done && req[owner_reg];
        end
      end
      default: gnt_next = '0;
    endcase
  end

  assign gnt         = gnt_reg;
  assign busy        = |gnt_reg;
  assign owner       = owner_reg;
  assign timeout_err = timeout_reg;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_reg));

  a_gnt_stable_busy: assert property (@(posedge clk) disable iff (rst)
    (state_reg == ARB_BUSY) |=> (state_reg != ARB_BUSY || $stable(gnt_reg)));

  a_gnt_gap_between_owners: assert property (@(posedge clk) disable iff (rst)
    (gnt_reg != '0) |=> (gnt_reg == '0 || gnt_reg == $past(gnt_reg)));

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Round-robin arbiter that owns the shared snoop bus and produces the one-hot `gnt` vector consumed by `snoop_bus`. It takes one request line per bus agent (cores and main memory, `NUM_CPUS` agents in total) and holds the grant for the full duration of a bus transaction. It releases the grant on a completion pulse and rotates priority so that no agent starves.

## Interface
- `NUM_CPUS`, from `types`: number of bus agents; must be ≥ 2.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles of continuous ownership; must be ≥ 1. Used only when `SNOOP_ARB_TIMEOUT_EN` is defined.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req`, input, `NUM_CPUS`: per-agent bus request, level-sensitive.
- `bus_done`, input, 1: single-cycle pulse from the current owner marking the end of its transaction.
- `gnt`, output, `NUM_CPUS`: registered grant vector, one-hot or zero.
- `busy`, output, 1: high while a grant is held; equals `|gnt`.
- `owner`, output, `$clog2(NUM_CPUS)`: index of the current grantee; holds its last value while idle.
- `timeout_err`, output, 1: one-cycle pulse when the watchdog forces a release.

## Operation
- FSM with three states:
  - IDLE: no grant held.
  - BUSY: grant held.
  - GAP: one dead cycle after each release.
- IDLE:
  - If `req != 0`, pick the first set `req` bit searching upward from `prio_ptr`, wrapping modulo `NUM_CPUS`.
  - Register `gnt` as one-hot of the winner, set `owner` to the winner, set `prio_ptr` to (winner+1) mod `NUM_CPUS`, and go to BUSY.
  - If `req == 0`, stay in IDLE.
- BUSY:
  - `gnt` is held constant; changes on `req` from other agents are ignored.
  - Release conditions, each taking effect on the next edge: `bus_done`=1; `req[owner]`=0 (owner abort); watchdog expiry.
  - On release, clear `gnt` and go to GAP.
- GAP:
  - `gnt`=0 for exactly one cycle, so snoopers observe `valid` low between transactions.
  - Then go to IDLE, where arbitration resumes in the same cycle.
- A `bus_done` pulse received in IDLE or GAP is ignored.
- `prio_ptr` width is `$clog2(NUM_CPUS)`. Compute the wrap explicitly (compare to `NUM_CPUS-1`) so that non-power-of-two `NUM_CPUS` works.
- Reset values: state=IDLE, `gnt`=0, `busy`=0, `owner`=0, `prio_ptr`=0, `timeout_err`=0, watchdog counter=0.
- Reset asserted mid-transaction drops `gnt` asynchronously. No completion is implied for the aborted transaction.

## Timing
- Grant latency: `req` sampled high in IDLE at edge N gives `gnt` high after edge N, i.e. visible in cycle N+1.
- Release: `bus_done` high in cycle M gives `gnt`=0 in cycle M+1 (GAP).
- The earliest next grant is visible in cycle M+3: M+1 is GAP, M+2 is IDLE sampling, M+3 is BUSY.
- Minimum ownership is 1 cycle: `bus_done` may arrive in the first BUSY cycle.
- If `bus_done` and watchdog expiry occur in the same cycle, `bus_done` wins and `timeout_err` stays 0.
- `gnt` never changes between two owners without passing through zero.

## Configuration
- `SNOOP_ARB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches `TIMEOUT_CYCLES` without a release, the arbiter forces a release and pulses `timeout_err` for the same cycle that `gnt` drops.
  - `prio_ptr` has already advanced past the offender.
- `SNOOP_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - `timeout_err` is tied 0; the port remains so the interface is unchanged.
  - Ownership is unbounded.

## Structure
- Add to the `types` package:
  - `arb_state_t` enum (ARB_IDLE, ARB_BUSY, ARB_GAP).
  - `ARB_TIMEOUT_CYCLES` default constant.
- Sub-module `rr_picker`: purely combinational. Takes `req` and `prio_ptr`; outputs `found` and `idx`. It is reused by any future multi-level arbitration.
- Assertions:
  - `$onehot0(gnt)` holds every cycle.
  - `gnt` holds stable while BUSY.
  - `gnt` is zero for ≥1 cycle between owners.

## Test plan
- Single request: `req`=0b0100 at cycle 2 → `gnt`=0b0100, `owner`=2 in cycle 3; `bus_done` at cycle 6 → `gnt`=0 in cycle 7.
- All request (NUM_CPUS=4, `req`=0b1111), each transaction ending with a 1-cycle `bus_done` → grant order 0,1,2,3,0 with a zero-`gnt` cycle between each.
- Fairness wrap: after agent 3 is served, `req`=0b1001 → agent 0 is granted next, not agent 3.
- Owner abort: agent 1 granted, then `req[1]` drops with no `bus_done` → `gnt`=0 next cycle; pending agent 2 is granted 2 cycles later.
- Watchdog (macro on, TIMEOUT_CYCLES=8): owner never sends `bus_done` → `timeout_err` pulses with `gnt`=0 exactly 8 BUSY cycles after the grant. Macro off: grant held indefinitely, `timeout_err` stays 0.
- Reset mid-BUSY: assert `rst` asynchronously while `gnt`=0b0010 → `gnt`=0 immediately; after deassertion, `prio_ptr`=0 and `req`=0b1010 grants agent 1.
